mem_apb_param: RTL and testbench
================================

Name: mem_apb_param

Overview:
- Parametrised APB4 memory slave; successor to the fixed 32-bit APB memory.
- Adds configurable data width and depth, programmable wait states, PSTRB byte-lane writes, and PSLVERR reporting for out-of-range and secure-region violations.
- Sits on an APB bridge output as a scratch/test memory for BFM-driven benches.

Parameters:
ADDR_WIDTH, 32, PADDR width.
DATA_WIDTH, 32, PRDATA/PWDATA width; legal values 8, 16, 32.
SIZE_IN_BYTES, 1024, memory size; power of two and a multiple of DATA_WIDTH/8.
DELAY, 0, wait states inserted per access; legal range 0..15.
SECURE_BYTES, 0, bytes [0, SECURE_BYTES) are secure-only; 0 disables the check.

Ports:
PCLK  input  1  clock, rising edge
PRESET  input  1  reset
PSEL  input  1  slave select
PADDR  input  ADDR_WIDTH  byte address
PENABLE  input  1  access phase
PWRITE  input  1  1=write, 0=read
PWDATA  input  DATA_WIDTH  write data
PSTRB  input  DATA_WIDTH/8  write byte enables
PPROT  input  3  protection; PPROT[1]=1 means non-secure
PRDATA  output  DATA_WIDTH  read data, registered
PREADY  output  1  transfer completion, registered
PSLVERR  output  1  error response, registered

Behaviour:
- Interface: one clock; reset is synchronous and active-high. The clock port is PCLK and the reset port is PRESET.
- Reset values: PREADY=0, PSLVERR=0, PRDATA=0, FSM=IDLE, wait counter=0. Memory contents are not reset.
- Word index: PADDR[log2(SIZE_IN_BYTES)-1 : log2(DATA_WIDTH/8)]. Lower address bits are ignored.
- Error condition ERR is true when either holds:
  - PADDR >= SIZE_IN_BYTES;
  - SECURE_BYTES != 0 and PPROT[1]=1 and PADDR < SECURE_BYTES.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - Setup is detected when PSEL=1 and PENABLE=0.
  - If DELAY=0: go to DONE and assert PREADY on the same edge.
  - Otherwise: load cnt=DELAY and go to WAIT.
- WAIT:
  - Decrement cnt each cycle.
  - When cnt=1, go to DONE and assert PREADY on that edge.
  - Result: the access phase lasts exactly DELAY+1 cycles.
- DONE:
  - This is the cycle where PREADY=1 and PSEL=PENABLE=1 (the completion edge).
  - Deassert PREADY and PSLVERR, clear PRDATA to 0, return to IDLE.
  - A new setup may be presented in the cycle immediately after.
- Read completion:
  - PRDATA is loaded from mem[index] on the edge that raises PREADY.
  - If ERR, PRDATA=0 instead.
  - PRDATA is held while PREADY=1 and is 0 at all other times.
- Write completion:
  - On the completion edge, byte lane i of mem[index] takes PWDATA lane i where PSTRB[i]=1.
  - Lanes with PSTRB[i]=0 are unchanged.
  - If ERR, nothing is written.
- PSLVERR is raised together with PREADY when ERR is true, for reads and writes alike.
- PSTRB is ignored on reads.
- Back-to-back write then read to the same address returns the new data, because the write commits before the read's setup edge.
- PSEL dropped while in WAIT (protocol violation): go to IDLE, no write, PREADY stays 0.
- PRESET asserted in any state: outputs go to reset values on that edge; a pending write is discarded.
- Address and control inputs are sampled in setup and must stay stable through the access phase (APB rule); the block does not re-latch them.

Test Plan:
- DATA_WIDTH=32, DELAY=0: write 0xDEADBEEF to 0x10 with PSTRB=0xF, then read 0x10 → PREADY high in the first access cycle, PRDATA=0xDEADBEEF, PSLVERR=0.
- DELAY=3: read 0x00 → PREADY low for 3 access cycles and high on the 4th; total transfer length 5 cycles including setup.
- Byte strobes: write 0x11223344 to 0x20, then write 0xAABBCCDD with PSTRB=0x5, then read 0x20 → PRDATA=0x11BB33DD.
- SIZE_IN_BYTES=1024, access 0x400 → PSLVERR=1 with PREADY; a following read of 0x3FC returns its unchanged prior content; an error read returns PRDATA=0.
- SECURE_BYTES=256: write with PPROT=3'b010 to 0x40 → PSLVERR=1, memory unchanged; write with PPROT=3'b000 to 0x40 → PSLVERR=0 and the write commits.
- DELAY=2: assert PRESET during the WAIT of a write to 0x8 holding 0x55 → PREADY=0, PSLVERR=0, PRDATA=0 next cycle; a later read of 0x8 returns the old value.

Source files
------------

// File: rtl/mem_apb_param.sv
// Parametrised APB4 memory slave with wait states, byte strobes and PSLVERR.
// Ports: PCLK/PRESET (sync, active-high), APB4 slave inputs PSEL, PADDR,
// PENABLE, PWRITE, PWDATA, PSTRB, PPROT; registered outputs PRDATA,
// PREADY, PSLVERR.
module mem_apb_param #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int SIZE_IN_BYTES = 1024,
    parameter int DELAY         = 0,
    parameter int SECURE_BYTES  = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic [2:0]              PPROT,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = SIZE_IN_BYTES / NB;
    localparam int LSB   = $clog2(NB);
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DLY = 4'(DELAY);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    pready_q, pready_d;
    logic                    pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
    logic                    mem_we;
    logic                    setup;
    logic                    raise;
    logic                    out_of_range;
    logic                    secure_hit;
    logic                    err;
    logic [IW-1:0]           idx;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    unused_prot;

    assign unused_prot  = ^{PPROT[2], PPROT[0]};
    assign idx          = PADDR[LSB +: IW];
    assign setup        = PSEL && !PENABLE;
    assign out_of_range = 64'(PADDR) >= 64'(SIZE_IN_BYTES);
    assign secure_hit   = (SECURE_BYTES != 0) && PPROT[1]
                          && (64'(PADDR) < 64'(SECURE_BYTES));
    assign err          = out_of_range || secure_hit;

    // State register
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (setup) state_d = (DELAY == 0) ? DONE : WAIT;
            WAIT: begin
                if (!PSEL)              state_d = IDLE;
                else if (cnt_q == 4'd1) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        cnt_d     = cnt_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        mem_we    = 1'b0;
        raise     = 1'b0;
        case (state_q)
            IDLE: begin
                if (setup) begin
                    cnt_d = DLY;
                    raise = (DELAY == 0);
                end
            end
            WAIT: begin
                cnt_d = PSEL ? cnt_q - 4'd1 : 4'd0;
                raise = PSEL && (cnt_q == 4'd1);
            end
            DONE: begin
                cnt_d  = 4'd0;
                // Write commits on the completion edge only.
                mem_we = PSEL && PENABLE && PWRITE && !err;
            end
            default: cnt_d = 4'd0;
        endcase
        if (raise) begin
            pready_d  = 1'b1;
            pslverr_d = err;
            if (!PWRITE && !err) prdata_d = mem[idx];
        end
    end

    // Memory array, no reset
    always_ff @(posedge PCLK) begin
        if (mem_we && !PRESET) begin
            for (int i = 0; i < NB; i++) begin
                if (PSTRB[i]) mem[idx][8*i +: 8] <= PWDATA[8*i +: 8];
            end
        end
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_mem_apb_param.sv
// Scoreboard bench for mem_apb_param: three instances with DELAY 0/3/2.
// Stimulus pushes expected responses; a negedge monitor pops and compares.
module tb_mem_apb_param;

    typedef struct {
        logic [31:0] rdata;
        bit          err;
        int          waits;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [2:0]  psel;
    logic [31:0] paddr;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata [3];
    logic        pready [3];
    logic        pslverr [3];

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   sel = 0;
    int   wcnt = 0;

    mem_apb_param #(.DELAY(0), .SECURE_BYTES(256)) u_d0 (
        .PCLK(clk), .PRESET(rst), .PSEL(psel[0]), .PADDR(paddr),
        .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata),
        .PSTRB(pstrb), .PPROT(pprot), .PRDATA(prdata[0]),
        .PREADY(pready[0]), .PSLVERR(pslverr[0])
    );

    mem_apb_param #(.DELAY(3)) u_d3 (
        .PCLK(clk), .PRESET(rst), .PSEL(psel[1]), .PADDR(paddr),
        .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata),
        .PSTRB(pstrb), .PPROT(pprot), .PRDATA(prdata[1]),
        .PREADY(pready[1]), .PSLVERR(pslverr[1])
    );

    mem_apb_param #(.DELAY(2)) u_d2 (
        .PCLK(clk), .PRESET(rst), .PSEL(psel[2]), .PADDR(paddr),
        .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata),
        .PSTRB(pstrb), .PPROT(pprot), .PRDATA(prdata[2]),
        .PREADY(pready[2]), .PSLVERR(pslverr[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compares every completed transfer against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            wcnt = 0;
        end else if (psel[sel] && penable) begin
            if (pready[sel]) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pready: got 1 expected 0");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk({e.name, "_prdata"}, prdata[sel], e.rdata);
                    chk({e.name, "_pslverr"}, 32'(pslverr[sel]),
                        32'(e.err));
                    chk({e.name, "_waits"}, 32'(wcnt), 32'(e.waits));
                end
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
        if (!rst && !pready[sel]) chk("prdata_idle_zero", prdata[sel], 0);
    end

    task automatic xfer(input int d, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] st,
                        input logic [2:0] pr, input logic [31:0] er,
                        input bit ee, input int ew, input string nm);
        exp_t e;
        e.rdata = er;
        e.err   = ee;
        e.waits = ew;
        e.name  = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        sel     = d;
        psel    = '0;
        psel[d] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = wd;
        pstrb   = st;
        pprot   = pr;
        @(posedge clk);
        #1;
        penable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pready[d]) return;
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: pready got 0 expected 1", nm);
        if (sb.size() > 0) void'(sb.pop_back());
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        psel    = '0;
        penable = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; psel = '0; paddr = '0; penable = 1'b0;
        pwrite = 1'b0; pwdata = '0; pstrb = '0; pprot = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_pready", 32'(pready[k]), 0);
            chk("rst_pslverr", 32'(pslverr[k]), 0);
            chk("rst_prdata", prdata[k], 0);
        end

        // DELAY=0, SECURE_BYTES=256 instance
        xfer(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, 0, 0, 0, "w10");
        xfer(0, 0, 32'h10, 0, 4'hF, 3'b000, 32'hDEADBEEF, 0, 0, "r10");
        xfer(0, 0, 32'h13, 0, 4'h0, 3'b000, 32'hDEADBEEF, 0, 0, "r13");
        xfer(0, 1, 32'h20, 32'h11223344, 4'hF, 3'b000, 0, 0, 0, "w20a");
        xfer(0, 1, 32'h20, 32'hAABBCCDD, 4'h5, 3'b000, 0, 0, 0, "w20b");
        xfer(0, 0, 32'h20, 0, 4'hF, 3'b000, 32'h11BB33DD, 0, 0, "r20");
        xfer(0, 1, 32'h0, 32'h01020304, 4'hF, 3'b000, 0, 0, 0, "w0");
        xfer(0, 1, 32'h3FC, 32'hCAFEF00D, 4'hF, 3'b000, 0, 0, 0, "w3fc");
        xfer(0, 1, 32'h400, 32'h99999999, 4'hF, 3'b000, 0, 1, 0, "w400");
        xfer(0, 0, 32'h400, 0, 4'hF, 3'b000, 0, 1, 0, "r400");
        xfer(0, 0, 32'h3FC, 0, 4'hF, 3'b000, 32'hCAFEF00D, 0, 0, "r3fc");
        xfer(0, 0, 32'h0, 0, 4'hF, 3'b000, 32'h01020304, 0, 0, "r0");
        xfer(0, 1, 32'h40, 32'h40404040, 4'hF, 3'b000, 0, 0, 0, "w40s");
        xfer(0, 1, 32'h40, 32'hBAD0BAD0, 4'hF, 3'b010, 0, 1, 0, "w40ns");
        xfer(0, 0, 32'h40, 0, 4'hF, 3'b000, 32'h40404040, 0, 0, "r40s");
        xfer(0, 0, 32'h40, 0, 4'hF, 3'b010, 0, 1, 0, "r40ns");
        xfer(0, 0, 32'hFF, 0, 4'hF, 3'b010, 0, 1, 0, "rffns");
        xfer(0, 1, 32'h100, 32'h0100CAFE, 4'hF, 3'b010, 0, 0, 0, "w100");
        xfer(0, 0, 32'h100, 0, 4'hF, 3'b010, 32'h0100CAFE, 0, 0, "r100");
        xfer(0, 1, 32'h40, 32'h00000077, 4'hF, 3'b000, 0, 0, 0, "w40b");
        xfer(0, 0, 32'h40, 0, 4'hF, 3'b000, 32'h00000077, 0, 0, "r40b");
        idle(2);

        // DELAY=3 instance
        xfer(1, 1, 32'h0, 32'h0A0B0C0D, 4'hF, 3'b000, 0, 0, 3, "d3w0");
        xfer(1, 0, 32'h0, 0, 4'hF, 3'b000, 32'h0A0B0C0D, 0, 3, "d3r0");
        xfer(1, 1, 32'h4, 32'h13579BDF, 4'hF, 3'b000, 0, 0, 3, "d3w4");
        @(posedge clk);
        #1;
        sel = 1; psel = 3'b010; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h4; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
        @(posedge clk);
        #1;
        penable = 1'b1;
        @(posedge clk);
        #1;
        psel = '0; penable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("psel_drop_pready", 32'(pready[1]), 0);
        end
        xfer(1, 0, 32'h4, 0, 4'hF, 3'b000, 32'h13579BDF, 0, 3, "d3r4");
        idle(2);

        // DELAY=2 instance: reset during WAIT of a write
        xfer(2, 1, 32'h8, 32'h12345678, 4'hF, 3'b000, 0, 0, 2, "d2w8");
        @(posedge clk);
        #1;
        sel = 2; psel = 3'b100; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h8; pwdata = 32'h00000055; pstrb = 4'hF;
        @(posedge clk);
        #1;
        penable = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstw_pready", 32'(pready[2]), 0);
        chk("rstw_pslverr", 32'(pslverr[2]), 0);
        chk("rstw_prdata", prdata[2], 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rstw_hold_pready", 32'(pready[2]), 0);
        end
        idle(1);
        xfer(2, 0, 32'h8, 0, 4'hF, 3'b000, 32'h12345678, 0, 2, "d2r8");
        idle(3);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
